// File: rtl/ram_sync_param.sv
// Synchronous single-port DATA_W x 2^ADDR_W RAM with registered reads and a clear sweep.
// Optional per-word even parity is enabled by defining RAM_SYNC_PARITY_EN.
module ram_sync_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              clr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              par_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef RAM_SYNC_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned WORD_W = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q;
    logic [DATA_W-1:0]   d_out_q;
    logic                rd_valid_q;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                rd_en;
    logic [WORD_W-1:0]   rd_word;

    assign rd_word = mem_q[addr];

    // Next-state, sweep pointer and memory port control; clr outranks any access.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        rd_en     = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ADDR_W'(ptr_q + 1'b1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (cs) begin
                    if (rw) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
`ifdef RAM_SYNC_PARITY_EN
                        mem_wdata = {^d_in, d_in};
`else
                        mem_wdata = d_in;
`endif
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            d_out_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= (state_d == CLEAR);
            rd_valid_q <= rd_en;
            if (rd_en) begin
                d_out_q <= rd_word[DATA_W-1:0];
            end
        end
    end

    // Array storage is deliberately unreset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef RAM_SYNC_PARITY_EN
    logic par_err_q;

    // XOR over data and stored parity is nonzero exactly when they disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (rd_en) begin
            par_err_q <= ^rd_word;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign d_out    = d_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param (DATA_W=8, ADDR_W=3); parity checks run when
// RAM_SYNC_PARITY_EN is defined.
module tb_ram_sync_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic              clr;
    logic [DATA_W-1:0] d_out;
    logic              rd_valid;
    logic              busy;
    logic              par_err;

    int n_vec = 0;
    int n_err = 0;

    ram_sync_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .d_in     (d_in),
        .clr      (clr),
        .d_out    (d_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cs = 1'b1; rw = 1'b1; addr = a; d_in = d;
        tick();
        cs = 1'b0; rw = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        cs = 1'b1; rw = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck sweep still reaches the summary.
    task automatic wait_busy(input string tag, input int exp);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 32'(n), 32'(exp));
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            do_read(ADDR_W'(a));
            check_val({tag, "_data"}, 32'(d_out), 32'h00);
            check_val({tag, "_vld"}, 32'(rd_valid), 32'h1);
            check_val({tag, "_par"}, 32'(par_err), 32'h0);
        end
        tick();
        check_val({tag, "_vld_end"}, 32'(rd_valid), 32'h0);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b0; addr = '0; d_in = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'h1);
        check_val("rst_dout", 32'(d_out), 32'h0);
        check_val("rst_vld", 32'(rd_valid), 32'h0);
        check_val("rst_par", 32'(par_err), 32'h0);

        rst = 1'b1;
        wait_busy("init_sweep_len", 8);
        read_all_zero("init_rd");

        // Write then read next cycle.
        do_write(3'd5, 8'hF0);
        check_val("wr_no_vld", 32'(rd_valid), 32'h0);
        do_read(3'd5);
        check_val("raw5_data", 32'(d_out), 32'hF0);
        check_val("raw5_vld", 32'(rd_valid), 32'h1);
        tick();
        check_val("raw5_vld_drop", 32'(rd_valid), 32'h0);
        check_val("raw5_hold", 32'(d_out), 32'hF0);

        // Back-to-back reads.
        do_write(3'd2, 8'h3C);
        do_write(3'd7, 8'hA5);
        do_read(3'd2);
        check_val("b2b_0", 32'(d_out), 32'h3C);
        check_val("b2b_0_vld", 32'(rd_valid), 32'h1);
        do_read(3'd7);
        check_val("b2b_1", 32'(d_out), 32'hA5);
        check_val("b2b_1_vld", 32'(rd_valid), 32'h1);
        do_read(3'd2);
        check_val("b2b_2", 32'(d_out), 32'h3C);
        check_val("b2b_2_vld", 32'(rd_valid), 32'h1);
        tick();
        check_val("b2b_end_vld", 32'(rd_valid), 32'h0);

        // clr wins over a simultaneous write.
        clr = 1'b1; cs = 1'b1; rw = 1'b1; addr = 3'd0; d_in = 8'hFF;
        tick();
        clr = 1'b0; cs = 1'b0; rw = 1'b0;
        check_val("clr_busy_rise", 32'(busy), 32'h1);
        // Accesses during the sweep must be ignored.
        cs = 1'b1; rw = 1'b0; addr = 3'd5;
        tick();
        cs = 1'b0;
        check_val("clr_rd_ignored", 32'(rd_valid), 32'h0);
        check_val("clr_dout_hold", 32'(d_out), 32'h3C);
        wait_busy("clr_sweep_len", 7);
        read_all_zero("clr_rd");

        // Reset mid-sweep restarts the full sweep.
        do_write(3'd3, 8'h5A);
        do_read(3'd3);
        check_val("pre_rst_data", 32'(d_out), 32'h5A);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check_val("midsweep_dout", 32'(d_out), 32'h0);
        check_val("midsweep_vld", 32'(rd_valid), 32'h0);
        check_val("midsweep_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_busy("restart_sweep_len", 8);
        do_read(3'd3);
        check_val("restart_cleared", 32'(d_out), 32'h00);

        // Reset during a read strobe.
        do_write(3'd4, 8'h77);
        do_read(3'd4);
        check_val("midread_pre_vld", 32'(rd_valid), 32'h1);
        rst = 1'b0;
        #1;
        check_val("midread_vld", 32'(rd_valid), 32'h0);
        check_val("midread_dout", 32'(d_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_busy("midread_sweep_len", 8);

`ifdef RAM_SYNC_PARITY_EN
        do_write(3'd1, 8'h81);
        dut.mem_q[1][DATA_W] = ~dut.mem_q[1][DATA_W];
        do_read(3'd1);
        check_val("par_flip_data", 32'(d_out), 32'h81);
        check_val("par_flip_err", 32'(par_err), 32'h1);
        tick();
        check_val("par_err_hold", 32'(par_err), 32'h1);
        do_write(3'd6, 8'h07);
        do_read(3'd6);
        check_val("par_clean_data", 32'(d_out), 32'h07);
        check_val("par_clean_err", 32'(par_err), 32'h0);
`else
        do_write(3'd1, 8'h81);
        do_read(3'd1);
        check_val("nopar_data", 32'(d_out), 32'h81);
        check_val("nopar_err", 32'(par_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised synchronous single-port RAM: the next generation of the team's word-organised RAM arrays. It replaces the fixed 8x8 structure with a configurable DATA_W x 2^ADDR_W array. Reads are registered with a one-cycle valid strobe, and a clear sequencer zeroes every word after reset or on request. It sits wherever a small scratch memory is needed behind a cs/rw-style bus, and the bus master must watch `busy`.

## Interface
- DATA_W, 8, word width in bits (>=1)
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W words (>=1)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset
- cs  input  1  chip select; access is taken only when cs=1 and busy=0
- rw  input  1  1 = write, 0 = read (qualified by cs)
- addr  input  ADDR_W  word address
- d_in  input  DATA_W  write data
- clr  input  1  bulk-clear request (sampled every edge)
- d_out  output  DATA_W  registered read data; holds last read value
- rd_valid  output  1  one-cycle strobe; d_out updated by a read this cycle
- busy  output  1  clear sweep in progress; all accesses ignored
- par_err  output  1  parity mismatch on the word in d_out (see Configuration)

## Operation
- FSM states: CLEAR, IDLE.
- rst low (any time, asynchronous): state=CLEAR, sweep pointer=0, busy=1, d_out=0, rd_valid=0, par_err=0. Memory contents are not reset directly; the sweep zeroes them.
- CLEAR: each edge writes 0 (and the matching parity bit) to mem[ptr], then ptr increments. After the write to DEPTH-1, the state goes to IDLE. cs, rw, addr, d_in and clr are ignored. rd_valid stays 0. d_out holds.
- IDLE, clr=1: go to CLEAR with ptr=0. Any cs access in the same cycle is dropped (clr has priority).
- IDLE, cs=1, rw=1: at the edge, mem[addr] <= d_in. d_out, rd_valid and par_err are unchanged (rd_valid=0).
- IDLE, cs=1, rw=0: at the edge, d_out <= mem[addr], rd_valid <= 1, par_err <= parity check.
- IDLE, cs=0: no access, rd_valid <= 0.
- Read-after-write to the same address in consecutive cycles returns the new data. No same-cycle bypass is needed, since single-port allows only one operation per edge.
- addr uses the full ADDR_W range; there is no out-of-range case. The sweep pointer is ADDR_W+1 bits wide, or a terminal-count compare, so it never wraps back into a second sweep.

## Timing
- Clear sweep takes exactly DEPTH cycles. busy is high from reset deassertion through the edge that writes word DEPTH-1, and is low after that edge.
- Clear sweep started by clr sampled at edge E: busy is high from E+1 through the DEPTH writes; the first access is accepted at edge E+DEPTH+1.
- Read latency is 1: addr is sampled at edge N, and d_out/rd_valid are valid after edge N until edge N+1.
- Back-to-back reads every cycle give rd_valid high continuously.
- Write latency: data is visible to a read issued at the next edge.
- rst asserted mid-sweep restarts the sweep from 0. rst asserted mid-read clears rd_valid and d_out immediately.

## Configuration
- Macro RAM_SYNC_PARITY_EN.
- Defined: each word stores DATA_W+1 bits, with an even-parity bit computed from d_in at write time (0 for cleared words). On read, par_err <= (stored parity != XOR of stored data), registered together with rd_valid. par_err holds until the next read or reset.
- Undefined: no parity storage or logic, and par_err is tied to 0.

## Test plan
- Reset, then release rst with DATA_W=8, ADDR_W=3 -> busy=1 for exactly 8 cycles, then 0. Reading all 8 addresses returns 0x00 with rd_valid pulses and par_err=0.
- After clear, write 0xF0 to addr 5, then read addr 5 next cycle -> d_out=0xF0 with rd_valid=1 one cycle after the read edge, then rd_valid=0.
- Write 0x3C to addr 2 and 0xA5 to addr 7, then read 2, 7, 2 back-to-back -> d_out=0x3C, 0xA5, 0x3C on consecutive cycles, with rd_valid high for 3 cycles.
- With data written, pulse clr together with a cs=1/rw=1 write of 0xFF to addr 0 -> the write is dropped, busy is high for 8 cycles, and all words then read 0x00.
- Assert rst for one cycle at sweep cycle 4 -> d_out=0 and rd_valid=0 immediately. The sweep restarts and busy stays high for a full 8 cycles after release.
- With RAM_SYNC_PARITY_EN: write 0x81 to addr 1, flip the stored parity bit hierarchically, read addr 1 -> d_out=0x81, par_err=1. A subsequent read of a clean address gives par_err=0. Without the macro, par_err stays 0 throughout.
